// File: rtl/lcd_timing_gen_if.sv
// Pixel-side bus of the LCD timing generator: runtime timing config plus the
// request/data handshake towards the frame-buffer reader.
interface lcd_timing_gen_if #(
  parameter int CNT_W  = 12,
  parameter int DATA_W = 24
);
  logic              cfg_valid;
  logic [CNT_W-1:0]  cfg_h_sync;
  logic [CNT_W-1:0]  cfg_h_back;
  logic [CNT_W-1:0]  cfg_h_disp;
  logic [CNT_W-1:0]  cfg_h_front;
  logic [CNT_W-1:0]  cfg_v_sync;
  logic [CNT_W-1:0]  cfg_v_back;
  logic [CNT_W-1:0]  cfg_v_disp;
  logic [CNT_W-1:0]  cfg_v_front;
  logic              cfg_pending;
  logic              cfg_err;
  logic [DATA_W-1:0] pix_data;
  logic              req;
  logic [CNT_W-1:0]  xpos;
  logic [CNT_W-1:0]  ypos;

  modport master (
    output cfg_valid, cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front,
           cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front, pix_data,
    input  cfg_pending, cfg_err, req, xpos, ypos
  );

  modport slave (
    input  cfg_valid, cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front,
           cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front, pix_data,
    output cfg_pending, cfg_err, req, xpos, ypos
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// Programmable LCD/VGA raster timing generator; all outputs registered one clock
// after the counter state they describe. New timing is shadowed until frame end.
module lcd_timing_gen #(
  parameter int CNT_W   = 12,
  parameter int DATA_W  = 24,
  parameter int AHEAD   = 1,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int H_SYNC  = 128,
  parameter int H_BACK  = 88,
  parameter int H_DISP  = 800,
  parameter int H_FRONT = 40,
  parameter int V_SYNC  = 4,
  parameter int V_BACK  = 23,
  parameter int V_DISP  = 600,
  parameter int V_FRONT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  lcd_timing_gen_if.slave   bus,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [DATA_W-1:0] lcd_rgb,
  output logic              frame_start
);
  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] LIM = SW'(1) << CNT_W;
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);
  // Field order everywhere: h_sync, h_back, h_disp, h_front, v_sync, v_back, v_disp, v_front
  localparam int DEF [8] = '{H_SYNC, H_BACK, H_DISP, H_FRONT,
                             V_SYNC, V_BACK, V_DISP, V_FRONT};

  logic [CNT_W-1:0]  w_in [8];
  logic [CNT_W-1:0]  r_act [8];
  logic [CNT_W-1:0]  r_shd [8];
  logic              r_pending;
  logic              r_err;
  logic [CNT_W-1:0]  r_hcnt;
  logic [CNT_W-1:0]  r_vcnt;
  logic              r_hs, r_vs, r_de, r_req, r_fs;
  logic [CNT_W-1:0]  r_xpos, r_ypos;
  logic [DATA_W-1:0] r_rgb;

  function automatic logic [SW-1:0] f_sum4(input logic [CNT_W-1:0] a, b, c, d);
    return SW'(a) + SW'(b) + SW'(c) + SW'(d);
  endfunction

  assign w_in[0] = bus.cfg_h_sync;
  assign w_in[1] = bus.cfg_h_back;
  assign w_in[2] = bus.cfg_h_disp;
  assign w_in[3] = bus.cfg_h_front;
  assign w_in[4] = bus.cfg_v_sync;
  assign w_in[5] = bus.cfg_v_back;
  assign w_in[6] = bus.cfg_v_disp;
  assign w_in[7] = bus.cfg_v_front;

  logic [SW-1:0] w_ht, w_vt, w_in_ht, w_in_vt;
  logic          w_cfg_ok, w_accept, w_apply_pt, w_h_last, w_v_last;

  assign w_ht    = f_sum4(r_act[0], r_act[1], r_act[2], r_act[3]);
  assign w_vt    = f_sum4(r_act[4], r_act[5], r_act[6], r_act[7]);
  assign w_in_ht = f_sum4(w_in[0], w_in[1], w_in[2], w_in[3]);
  assign w_in_vt = f_sum4(w_in[4], w_in[5], w_in[6], w_in[7]);

  // Sums are taken two bits wider than the fields so an oversized total cannot wrap
  assign w_cfg_ok = (w_in[2] != '0) && (w_in[6] != '0) &&
                    (w_in[0] != '0) && (w_in[4] != '0) &&
                    ((SW'(w_in[0]) + SW'(w_in[1])) >= SW'(AHEAD)) &&
                    (w_in_ht <= LIM) && (w_in_vt <= LIM);
  assign w_accept = bus.cfg_valid && w_cfg_ok;

  logic [SW-1:0] w_hc, w_vc, w_h_start, w_h_end, w_v_start, w_v_end, w_req_lo, w_req_hi;
  logic          w_v_win, w_de, w_req;

  assign w_hc       = {2'b00, r_hcnt};
  assign w_vc       = {2'b00, r_vcnt};
  assign w_h_last   = (w_hc == w_ht - SW'(1));
  assign w_v_last   = (w_vc == w_vt - SW'(1));
  assign w_apply_pt = w_h_last && w_v_last;

  assign w_h_start = SW'(r_act[0]) + SW'(r_act[1]);
  assign w_h_end   = w_h_start + SW'(r_act[2]);
  assign w_v_start = SW'(r_act[4]) + SW'(r_act[5]);
  assign w_v_end   = w_v_start + SW'(r_act[6]);
  assign w_req_lo  = w_h_start - SW'(AHEAD);
  assign w_req_hi  = w_h_end - SW'(AHEAD);

  assign w_v_win = (w_vc >= w_v_start) && (w_vc < w_v_end);
  assign w_de    = w_v_win && (w_hc >= w_h_start) && (w_hc < w_h_end);
  assign w_req   = w_v_win && (w_hc >= w_req_lo) && (w_hc < w_req_hi);

  // Timing config: shadow captures every accepted cfg, active swaps only at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_act[i] <= CNT_W'(DEF[i]);
        r_shd[i] <= CNT_W'(DEF[i]);
      end
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_apply_pt && w_accept)
          r_act[i] <= w_in[i];
        else if (w_apply_pt && r_pending)
          r_act[i] <= r_shd[i];
        if (w_accept)
          r_shd[i] <= w_in[i];
      end
      if (w_apply_pt)
        r_pending <= 1'b0;
      else if (w_accept)
        r_pending <= 1'b1;
      r_err <= bus.cfg_valid && !w_cfg_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_last) begin
      r_hcnt <= '0;
      r_vcnt <= w_v_last ? '0 : r_vcnt + CNT_W'(1);
    end else begin
      r_hcnt <= r_hcnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs   <= ~HS_ON;
      r_vs   <= ~VS_ON;
      r_de   <= 1'b0;
      r_req  <= 1'b0;
      r_xpos <= '0;
      r_ypos <= '0;
      r_rgb  <= '0;
      r_fs   <= 1'b0;
    end else begin
      r_hs   <= (w_hc < SW'(r_act[0])) ? HS_ON : ~HS_ON;
      r_vs   <= (w_vc < SW'(r_act[4])) ? VS_ON : ~VS_ON;
      r_de   <= w_de;
      r_req  <= w_req;
      r_xpos <= w_req ? CNT_W'(w_hc - w_req_lo) : '0;
      r_ypos <= w_req ? CNT_W'(w_vc - w_v_start) : '0;
      r_rgb  <= w_de ? bus.pix_data : '0;
      r_fs   <= (r_hcnt == '0) && (r_vcnt == '0);
    end
  end

  assign bus.cfg_pending = r_pending;
  assign bus.cfg_err     = r_err;
  assign bus.req         = r_req;
  assign bus.xpos        = r_xpos;
  assign bus.ypos        = r_ypos;
  assign lcd_hs          = r_hs;
  assign lcd_vs          = r_vs;
  assign lcd_de          = r_de;
  assign lcd_rgb         = r_rgb;
  assign frame_start     = r_fs;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: small default raster, AHEAD=2 with a registered
// pixel RAM, frame-position reference model checked every cycle.
module tb_lcd_timing_gen;
  localparam int CNT_W  = 12;
  localparam int DATA_W = 24;
  localparam int AHEAD  = 2;
  localparam int HP     = 0;
  localparam int VP     = 0;
  localparam int D [8]  = '{4, 3, 10, 2, 2, 2, 5, 1};  // Ht=19, Vt=10

  logic clk = 1'b0;
  logic rst_n;
  logic lcd_hs, lcd_vs, lcd_de, frame_start;
  logic [DATA_W-1:0] lcd_rgb;

  lcd_timing_gen_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) ifc ();

  lcd_timing_gen #(
    .CNT_W(CNT_W), .DATA_W(DATA_W), .AHEAD(AHEAD), .HS_POL(HP), .VS_POL(VP),
    .H_SYNC(D[0]), .H_BACK(D[1]), .H_DISP(D[2]), .H_FRONT(D[3]),
    .V_SYNC(D[4]), .V_BACK(D[5]), .V_DISP(D[6]), .V_FRONT(D[7])
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de),
    .lcd_rgb(lcd_rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Frame-buffer reader with one-cycle read latency; pixel value encodes (y,x)
  always @(posedge clk) ifc.pix_data <= ifc.req ? {ifc.ypos, ifc.xpos} : '0;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_total++;
    n_bad++;
    $display("FAIL %s timeout t=%0t", nm, $time);
  endtask

  // Reference model: position within the frame plus active/shadow timing
  int m_act [8];
  int m_sh [8];
  int m_p;
  int m_pend;
  int e_hs, e_vs, e_de, e_req, e_x, e_y, e_rgb, e_fs, e_err, e_pend;

  function automatic int cfg_ok(input int c [8]);
    int ht, vt;
    ht = c[0] + c[1] + c[2] + c[3];
    vt = c[4] + c[5] + c[6] + c[7];
    return (c[2] != 0 && c[6] != 0 && c[0] != 0 && c[4] != 0 &&
            c[0] + c[1] >= AHEAD && ht <= (1 << CNT_W) && vt <= (1 << CNT_W)) ? 1 : 0;
  endfunction

  function automatic int m_tot();
    return (m_act[0] + m_act[1] + m_act[2] + m_act[3]) *
           (m_act[4] + m_act[5] + m_act[6] + m_act[7]);
  endfunction

  task automatic model_reset();
    m_act = D;
    m_sh  = D;
    m_p = 0; m_pend = 0;
    e_hs = 1 - HP; e_vs = 1 - VP;
    e_de = 0; e_req = 0; e_x = 0; e_y = 0; e_rgb = 0; e_fs = 0; e_err = 0; e_pend = 0;
  endtask

  task automatic model_step();
    int c [8];
    int ht, vt, h, v, hst, hen, vst, ven, ok;
    bit vwin;
    c[0] = int'(ifc.cfg_h_sync); c[1] = int'(ifc.cfg_h_back);
    c[2] = int'(ifc.cfg_h_disp); c[3] = int'(ifc.cfg_h_front);
    c[4] = int'(ifc.cfg_v_sync); c[5] = int'(ifc.cfg_v_back);
    c[6] = int'(ifc.cfg_v_disp); c[7] = int'(ifc.cfg_v_front);
    ht = m_act[0] + m_act[1] + m_act[2] + m_act[3];
    vt = m_act[4] + m_act[5] + m_act[6] + m_act[7];
    h = m_p % ht;
    v = m_p / ht;
    hst = m_act[0] + m_act[1]; hen = hst + m_act[2];
    vst = m_act[4] + m_act[5]; ven = vst + m_act[6];
    vwin  = (v >= vst) && (v < ven);
    e_hs  = (h < m_act[0]) ? HP : 1 - HP;
    e_vs  = (v < m_act[4]) ? VP : 1 - VP;
    e_de  = (vwin && h >= hst && h < hen) ? 1 : 0;
    e_req = (vwin && h >= hst - AHEAD && h < hen - AHEAD) ? 1 : 0;
    e_x   = e_req ? h - (hst - AHEAD) : 0;
    e_y   = e_req ? v - vst : 0;
    e_rgb = e_de ? (((v - vst) << 12) | (h - hst)) : 0;
    e_fs  = (m_p == 0) ? 1 : 0;
    ok    = cfg_ok(c);
    e_err = (ifc.cfg_valid && ok == 0) ? 1 : 0;
    if (m_p == ht * vt - 1) begin
      m_p = 0;
      if (ifc.cfg_valid && ok != 0) m_act = c;
      else if (m_pend != 0)          m_act = m_sh;
      m_pend = 0;
    end else begin
      m_p++;
      if (ifc.cfg_valid && ok != 0) begin
        m_sh = c;
        m_pend = 1;
      end
    end
    e_pend = m_pend;
  endtask

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  always begin
    @(negedge clk);
    if (chk_en) begin
      chk("hs",   32'(lcd_hs),          e_hs);
      chk("vs",   32'(lcd_vs),          e_vs);
      chk("de",   32'(lcd_de),          e_de);
      chk("rgb",  32'(lcd_rgb),         e_rgb);
      chk("req",  32'(ifc.req),         e_req);
      chk("xpos", 32'(ifc.xpos),        e_x);
      chk("ypos", 32'(ifc.ypos),        e_y);
      chk("fs",   32'(frame_start),     e_fs);
      chk("err",  32'(ifc.cfg_err),     e_err);
      chk("pend", 32'(ifc.cfg_pending), e_pend);
    end
  end

  // Drives one cfg strobe starting at the current negedge; returns one clock later
  task automatic send_cfg(input int hs, hb, hd, hf, vs, vb, vd, vf);
    ifc.cfg_h_sync = 12'(hs); ifc.cfg_h_back = 12'(hb);
    ifc.cfg_h_disp = 12'(hd); ifc.cfg_h_front = 12'(hf);
    ifc.cfg_v_sync = 12'(vs); ifc.cfg_v_back = 12'(vb);
    ifc.cfg_v_disp = 12'(vd); ifc.cfg_v_front = 12'(vf);
    ifc.cfg_valid = 1'b1;
    @(negedge clk);
    ifc.cfg_valid = 1'b0;
  endtask

  // Period between frame_start pulses plus de / hs-active counts over one frame
  task automatic measure(input string nm, input int e_per, input int e_nde, input int e_nhs);
    int per, nde, nhs;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (frame_start) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin timeout({nm, "_start"}); return; end
    per = 0; nde = 0; nhs = 0; ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      per++;
      if (lcd_de) nde++;
      if (lcd_hs == 1'(HP)) nhs++;
      if (frame_start) begin ok = 1'b1; break; end
    end
    if (!ok) begin timeout({nm, "_end"}); return; end
    $display("frame %s: period=%0d de=%0d hs=%0d", nm, per, nde, nhs);
    chk({nm, "_period"}, per, e_per);
    chk({nm, "_de"},     nde, e_nde);
    chk({nm, "_hs"},     nhs, e_nhs);
  endtask

  task automatic wait_apply();
    for (int i = 0; i < 5000; i++) begin
      if (m_p == m_tot() - 1) return;
      @(negedge clk);
    end
    timeout("apply_point");
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.cfg_valid = 1'b0;
    ifc.cfg_h_sync = '0; ifc.cfg_h_back = '0; ifc.cfg_h_disp = '0; ifc.cfg_h_front = '0;
    ifc.cfg_v_sync = '0; ifc.cfg_v_back = '0; ifc.cfg_v_disp = '0; ifc.cfg_v_front = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_hs", 32'(lcd_hs), 1);
    chk("rst_de", 32'(lcd_de), 0);
    chk("rst_fs", 32'(frame_start), 0);
    $display("reset applied");

    // Defaults: Ht=19, Vt=10; first frame_start one clock after release
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_fs", 32'(frame_start), 1);
    measure("default", 190, 50, 40);

    // Mid-frame cfg: 3/2/6/1, 1/2/4/2 -> Ht=12, Vt=9
    repeat (40) @(negedge clk);
    send_cfg(3, 2, 6, 1, 1, 2, 4, 2);
    chk("cfgA_pend", 32'(ifc.cfg_pending), 1);
    $display("cfg A sent");
    measure("cfgA", 108, 24, 27);
    chk("cfgA_pend_clr", 32'(ifc.cfg_pending), 0);

    // Rejections: zero h_disp, Ht=5000, sync+back below AHEAD
    send_cfg(4, 3, 0, 2, 2, 2, 5, 1);
    chk("rej_disp_err", 32'(ifc.cfg_err), 1);
    chk("rej_disp_pend", 32'(ifc.cfg_pending), 0);
    send_cfg(500, 400, 4000, 100, 2, 2, 5, 1);
    chk("rej_ht_err", 32'(ifc.cfg_err), 1);
    chk("rej_ht_pend", 32'(ifc.cfg_pending), 0);
    send_cfg(1, 0, 8, 2, 2, 2, 5, 1);
    chk("rej_ahead_err", 32'(ifc.cfg_err), 1);
    $display("rejected cfgs sent");
    measure("after_rej", 108, 24, 27);

    // Two cfgs in one frame; the second lands exactly on the apply cycle
    repeat (10) @(negedge clk);
    send_cfg(2, 1, 8, 3, 3, 1, 3, 1);
    chk("cfgB_pend", 32'(ifc.cfg_pending), 1);
    wait_apply();
    send_cfg(2, 2, 7, 2, 2, 1, 4, 1);
    chk("cfgC_pend", 32'(ifc.cfg_pending), 0);
    $display("cfg B then C on apply cycle");
    measure("cfgC", 104, 28, 16);

    // Reset mid-line with a pending cfg
    repeat (5) @(negedge clk);
    send_cfg(3, 2, 6, 1, 1, 2, 4, 2);
    chk("pre_rst_pend", 32'(ifc.cfg_pending), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pend", 32'(ifc.cfg_pending), 0);
    chk("mid_rst_hs",   32'(lcd_hs), 1);
    chk("mid_rst_req",  32'(ifc.req), 0);
    chk("mid_rst_rgb",  32'(lcd_rgb), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_first_fs", 32'(frame_start), 1);
    $display("mid-frame reset released");
    measure("post_rst", 190, 50, 40);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
